// File: rtl/a2d_intf.sv
// a2d_intf: SPI mode-3 master for an ADC128S-style converter.
// Accepts a channel and start strobe, runs two 16-bit frames, and returns
// the 12-bit result with a level completion flag.
// Optional feature macro: A2D_CHNNL_REUSE_EN. When it is defined, a repeat
// request for the last completed channel skips the first frame and the gap.
//
// state | meaning
// IDLE  | waiting for strt_cnv; SS_n high, SCLK high
// TXN1  | first frame; addresses the channel, returned data discarded
// GAP   | SS_n high for GAP_CLKS cycles between frames
// TXN2  | second frame; returned data becomes res

module a2d_intf #(
    parameter int GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int GW = $clog2(GAP_CLKS);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CLKS - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [4:0]    DIV_PRE  = 5'b10111;
    // The start edge both preloads and counts, so the first SCLK fall lands
    // eight clocks after SS_n drops.
    localparam logic [4:0]    DIV_START = DIV_PRE + 5'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TXN1 = 2'd1,
        GAP  = 2'd2,
        TXN2 = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [4:0]      r_div;
    logic [4:0]      r_fall_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [15:0]     r_shift;
    logic            r_miso;
    logic [2:0]      r_chnnl;
    logic            r_ss_n;
    logic            r_cnv_cmplt;
    logic [11:0]     r_res;

    logic            w_accept;
    logic            w_in_txn;
    logic            w_sclk_rise;
    logic            w_sclk_fall;
    logic            w_frame_end;
    logic            w_txn2_done;
    logic            w_gap_done;
    logic            w_reuse_hit;
    logic [15:0]     w_cmd;
    logic [15:0]     w_cmd_new;
    logic [15:0]     w_shift_in;

    assign w_accept    = (r_state == IDLE) && strt_cnv;
    assign w_in_txn    = (r_state == TXN1) || (r_state == TXN2);
    assign w_sclk_rise = w_in_txn && (r_div == 5'd15);
    assign w_sclk_fall = w_in_txn && (r_div == 5'd31);
    // After the 16th fall the divider wraps through 0..23; 23 is the edge
    // where a 17th fall would otherwise begin, so the frame closes there.
    assign w_frame_end = w_in_txn && (r_fall_cnt == 5'd16) && (r_div == DIV_PRE);
    assign w_txn2_done = w_frame_end && (r_state == TXN2);
    assign w_gap_done  = (r_state == GAP) && (r_gap_cnt == '0);
    assign w_cmd       = {2'b00, r_chnnl, 11'h000};
    assign w_cmd_new   = {2'b00, chnnl, 11'h000};
    assign w_shift_in  = {r_shift[14:0], r_miso};

`ifdef A2D_CHNNL_REUSE_EN
    logic [2:0] r_last_ch;
    logic       r_last_vld;

    assign w_reuse_hit = r_last_vld && (r_last_ch == chnnl);

    // Remember the channel addressed by the last completed conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_ch  <= '0;
            r_last_vld <= 1'b0;
        end else if (w_txn2_done) begin
            r_last_ch  <= r_chnnl;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_reuse_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (strt_cnv)    w_state_nxt = w_reuse_hit ? TXN2 : TXN1;
            TXN1: if (w_frame_end) w_state_nxt = GAP;
            GAP:  if (w_gap_done)  w_state_nxt = TXN2;
            TXN2: if (w_frame_end) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // SCLK divider and falling-edge counter; both rest at zero outside frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_fall_cnt <= '0;
        end else if (w_accept || w_gap_done) begin
            r_div      <= DIV_START;
            r_fall_cnt <= '0;
        end else if (w_frame_end || !w_in_txn) begin
            r_div      <= '0;
            r_fall_cnt <= '0;
        end else begin
            r_div <= r_div + 5'd1;
            if (w_sclk_fall) r_fall_cnt <= r_fall_cnt + 5'd1;
        end
    end

    // Inter-frame gap down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n)                                  r_gap_cnt <= '0;
        else if (w_frame_end && (r_state == TXN1))   r_gap_cnt <= GAP_LOAD;
        else if ((r_state == GAP) && !w_gap_done)    r_gap_cnt <= r_gap_cnt - GAP_ONE;
    end

    // Shift register: command out on MOSI, converter data in from MISO.
    // The first fall leaves bit 15 in place because it has not been sampled yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_miso  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= w_cmd_new;
        end else if (w_frame_end) begin
            r_shift <= (r_state == TXN1) ? w_cmd : 16'h0000;
        end else begin
            if (w_sclk_rise) r_miso <= MISO;
            if (w_sclk_fall && (r_fall_cnt != 5'd0)) r_shift <= w_shift_in;
        end
    end

    // Chip select, latched channel, result and completion flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ss_n      <= 1'b1;
            r_chnnl     <= '0;
            r_cnv_cmplt <= 1'b0;
            r_res       <= '0;
        end else begin
            if (w_accept) begin
                r_chnnl     <= chnnl;
                r_cnv_cmplt <= 1'b0;
            end
            if (w_accept || w_gap_done) r_ss_n <= 1'b0;
            else if (w_frame_end)       r_ss_n <= 1'b1;
            if (w_txn2_done) begin
                r_res       <= w_shift_in[11:0];
                r_cnv_cmplt <= 1'b1;
            end
        end
    end

    assign SS_n      = r_ss_n;
    assign SCLK      = w_in_txn ? r_div[4] : 1'b1;
    assign MOSI      = r_shift[15];
    assign cnv_cmplt = r_cnv_cmplt;
    assign res       = r_res;

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a small ADC128S-style converter model.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    always #5 clk = ~clk;

    a2d_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    // Converter model: returns data for the channel addressed in the previous
    // frame, MSB first, advancing after each SCLK rise; records MOSI per frame.
    logic [11:0] adc_val [8];
    logic [15:0] adc_word  = 16'h0000;
    logic [4:0]  bit_idx   = 5'h1F;
    logic [15:0] cmd_sh    = 16'h0000;
    logic [2:0]  last_addr = 3'd0;
    int          rise_cnt  = 0;
    logic [15:0] frame_q [$];

    assign MISO = bit_idx[4] ? 1'b0 : adc_word[bit_idx[3:0]];

    always @(negedge SS_n) begin
        adc_word = {4'h0, adc_val[last_addr]};
        bit_idx  = 5'd15;
        cmd_sh   = 16'h0000;
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            cmd_sh   = {cmd_sh[14:0], MOSI};
            bit_idx  = bit_idx - 5'd1;
            rise_cnt = rise_cnt + 1;
        end
    end

    always @(posedge SS_n) begin
        frame_q.push_back(cmd_sh);
        last_addr = cmd_sh[13:11];
    end

    int n_chk  = 0;
    int n_pass = 0;
    int t      = 0;

    bit         tb_prev_vld = 1'b0;
    logic [2:0] tb_prev_ch  = 3'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to "after edge E0+n"; sampling happens 1 time unit past the edge.
    task automatic go(input int n);
        while (t < n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    // Present a request for one edge; that edge is E0. chnnl is then scrambled
    // to show that later changes are ignored.
    task automatic start_req(input logic [2:0] ch);
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        chnnl    = ch ^ 3'b101;
        t        = 0;
    endtask

    task automatic poke(input int at);
        go(at - 1);
        strt_cnv = 1'b1;
        chnnl    = 3'd2;
        go(at);
        strt_cnv = 1'b0;
        go(at + 1);
        chk("busy_ssn", 32'(SS_n), 32'd0);
    endtask

    task automatic run_conv(input logic [2:0] ch, input bit busy, input string tg);
        bit hit;
        int end_off;
        int n_frames;
        logic [15:0] cmd;
`ifdef A2D_CHNNL_REUSE_EN
        hit = tb_prev_vld && (tb_prev_ch == ch);
`else
        hit = 1'b0;
`endif
        end_off  = hit ? 512 : 1056;
        n_frames = hit ? 1 : 2;
        cmd      = {2'b00, ch, 11'h000};
        frame_q.delete();
        rise_cnt = 0;
        start_req(ch);
        chk($sformatf("%s_ssn_e0", tg), 32'(SS_n), 32'd0);
        go(7);
        chk($sformatf("%s_sclk_e7", tg), 32'(SCLK), 32'd1);
        go(8);
        chk($sformatf("%s_sclk_e8", tg), 32'(SCLK), 32'd0);
        go(24);
        chk($sformatf("%s_sclk_e24", tg), 32'(SCLK), 32'd1);
        if (!hit) begin
            if (busy) poke(300);
            go(511);
            chk($sformatf("%s_ssn_e511", tg), 32'(SS_n), 32'd0);
            go(512);
            chk($sformatf("%s_ssn_e512", tg), 32'(SS_n), 32'd1);
            chk($sformatf("%s_sclk_e512", tg), 32'(SCLK), 32'd1);
            go(543);
            chk($sformatf("%s_ssn_e543", tg), 32'(SS_n), 32'd1);
            go(544);
            chk($sformatf("%s_ssn_e544", tg), 32'(SS_n), 32'd0);
            go(552);
            chk($sformatf("%s_sclk_e552", tg), 32'(SCLK), 32'd0);
            if (busy) poke(700);
        end
        go(end_off - 1);
        chk($sformatf("%s_cmplt_pre", tg), 32'(cnv_cmplt), 32'd0);
        go(end_off);
        chk($sformatf("%s_cmplt", tg), 32'(cnv_cmplt), 32'd1);
        chk($sformatf("%s_ssn_end", tg), 32'(SS_n), 32'd1);
        chk($sformatf("%s_res", tg), 32'(res), 32'(adc_val[ch]));
        chk($sformatf("%s_frames", tg), 32'(frame_q.size()), 32'(n_frames));
        foreach (frame_q[i]) chk($sformatf("%s_cmd%0d", tg, i), 32'(frame_q[i]), 32'(cmd));
        chk($sformatf("%s_rises", tg), 32'(rise_cnt), 32'(16 * n_frames));
        tb_prev_vld = 1'b1;
        tb_prev_ch  = ch;
    endtask

    logic [2:0] chans [3];
    int         rc;

    initial begin
        adc_val[0] = 12'h111; adc_val[1] = 12'h222; adc_val[2] = 12'h0F0; adc_val[3] = 12'h3C3;
        adc_val[4] = 12'h4B4; adc_val[5] = 12'hA5C; adc_val[6] = 12'h666; adc_val[7] = 12'h777;
        chans[0] = 3'd0; chans[1] = 3'd7; chans[2] = 3'd0;
        rst_n    = 1'b0;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ssn",   32'(SS_n),      32'd1);
        chk("rst_sclk",  32'(SCLK),      32'd1);
        chk("rst_mosi",  32'(MOSI),      32'd0);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_res",   32'(res),       32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic conversion on channel 5.
        run_conv(3'd5, 1'b0, "basic");

        // Reset held for two clocks in the middle of the second frame.
        start_req(3'd6);
        go(700);
        chk("mid_res_hold", 32'(res),       32'h0A5C);
        chk("mid_cmplt",    32'(cnv_cmplt), 32'd0);
        chk("mid_ssn",      32'(SS_n),      32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_ssn",   32'(SS_n),      32'd1);
        chk("mrst_sclk",  32'(SCLK),      32'd1);
        chk("mrst_mosi",  32'(MOSI),      32'd0);
        chk("mrst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("mrst_res",   32'(res),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tb_prev_vld = 1'b0;
        rc = rise_cnt;
        repeat (100) @(posedge clk);
        #1;
        chk("mrst_no_sclk", 32'(rise_cnt),  32'(rc));
        chk("mrst_ssn_idle", 32'(SS_n),     32'd1);
        chk("mrst_cmplt_idle", 32'(cnv_cmplt), 32'd0);

        // Requests while busy are ignored.
        adc_val[5] = 12'h3C1;
        run_conv(3'd5, 1'b1, "busy");

        // Back-to-back with strt_cnv held high, alternating channels 0/7/0.
        strt_cnv = 1'b1;
        chnnl    = chans[0];
        @(posedge clk);
        #1;
        t = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b%0d_ssn", i),   32'(SS_n),      32'd0);
            chk($sformatf("b2b%0d_cmplt0", i), 32'(cnv_cmplt), 32'd0);
            if (i < 2) chnnl = chans[i + 1];
            else       strt_cnv = 1'b0;
            go(1055);
            chk($sformatf("b2b%0d_pre", i),   32'(cnv_cmplt), 32'd0);
            go(1056);
            chk($sformatf("b2b%0d_cmplt", i), 32'(cnv_cmplt), 32'd1);
            chk($sformatf("b2b%0d_res", i),   32'(res),       32'(adc_val[chans[i]]));
            go(1057);
            if (i < 2) t = 0;
        end
        chk("b2b_hold_cmplt", 32'(cnv_cmplt), 32'd1);
        chk("b2b_hold_ssn",   32'(SS_n),      32'd1);
        tb_prev_vld = 1'b1;
        tb_prev_ch  = chans[2];

        // Channel sweep with the channel number as the converter value.
        for (int c = 0; c < 8; c++) begin
            adc_val[c[2:0]] = {9'h000, c[2:0]};
            run_conv(c[2:0], 1'b0, $sformatf("sweep%0d", c));
        end

        // Repeat of one channel, then a different one.
        adc_val[3] = 12'hC35;
        adc_val[4] = 12'h5A4;
        run_conv(3'd3, 1'b0, "reuse_a");
        run_conv(3'd3, 1'b0, "reuse_b");
        run_conv(3'd4, 1'b0, "reuse_c");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
